jpeg_output_cvt: RTL and testbench
==================================

Name: jpeg_output_cvt

Overview:
Parametrised next-generation pixel emitter for the baseline JPEG decoder. It sits between the Y/Cb/Cr sample buffers, which already upsample chroma, plus the block-info FIFO on one side, and the pixel output port on the other. It sequences 8x8 blocks and performs a pipelined YCbCr->RGB conversion of LANES pixels per beat. It adds 4:2:2 support, true saturation, and edge-cropping masks for images that are not a multiple of 8 pixels.

Parameters:
LANES, 1, pixels per output beat; legal values 1, 2, 4, 8.
COEF_FRAC, 12, fractional bits of the colour-conversion coefficients.
LEVEL_W, 32, width of the buffer level inputs.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
img_start_i  in  1  new image; flushes all state
img_width_i  in  16  image width in pixels
img_height_i  in  16  image height in pixels
img_mode_i  in  2  0 mono, 1 444, 2 420, 3 422
y_level_i  in  LEVEL_W  luma samples buffered
cb_level_i  in  LEVEL_W  Cb samples buffered
cr_level_i  in  LEVEL_W  Cr samples buffered
y_data_i  in  LANES*32  signed luma samples; lane k = bits [32k+31:32k]
cb_data_i  in  LANES*32  signed Cb samples, aligned with luma
cr_data_i  in  LANES*32  signed Cr samples, aligned with luma
smp_pop_o  out  1  pops LANES samples from all three buffers
id_valid_i  in  1  info FIFO head valid
id_data_i  in  32  [31:30] type (3 = EOF), [29:16] block y, [15:0] block x
id_pop_o  out  1  pops info FIFO
outport_valid_o  out  1  beat valid
outport_accept_i  in  1  sink accepts beat
outport_pixel_x_o  out  16  x of lane 0
outport_pixel_y_o  out  16  y of beat
outport_rgb_o  out  LANES*24  lane k = {r,g,b} at [24k+23:24k]
outport_mask_o  out  LANES  lane k inside image
outport_last_o  out  1  final beat of the 8x8 block
idle_o  out  1  no image in progress

Behaviour:
- Reset (rst_ni low at posedge): all outputs 0 except idle_o=1. All counters and pipeline valids cleared. Reset takes priority over img_start_i.
- img_start_i: clears idx, subsample counter, active flag and pipeline valids; drives idle_o 0 on the next cycle.
- adv = active && (!s1_valid || pipe_en); pipe_en = !outport_valid_o || outport_accept_i. The whole pipeline stalls together.
- Activation (evaluated when not active): mono needs y>=64; 444 needs y,cb,cr>=64; 420 needs sub==0 and all three >=256, or sub!=0; 422 needs sub[0]==0 and all three >=128, or sub[0]==1.
- idx counts 0..63 in steps of LANES. smp_pop_o = adv.
- On adv with idx==64-LANES: idx wraps to 0, active clears, id_pop_o=1 for that cycle, and sub increments (420: mod 4; 422: mod 2).
- id_pop_o is never asserted when id_valid_i=0. While id_valid_i=0, active is held 0.
- Stage 1, registered: per-lane products cr*5743, cr*2925, cb*1410, cb*7258, each arithmetic-shifted right by COEF_FRAC. x = {id[15:0],3'b0} + idx%8 and y = {id[29:16],3'b0} + idx/8 are captured with the beat, together with last and eof flags.
- Stage 2 = output register. R = 128+Y+crA; G = 128+Y-cbA-crB; B = 128+Y+cbB. Mono: R=G=B=128+Y. Each value saturates: <0 -> 0, >255 -> 255.
- mask[k] = (x+k < width) && (y < height).
- The output beat is suppressed (valid stays 0) if mask==0 or eof.
- Latency: pop at cycle t gives output valid at t+2 when unstalled. Output holds stable while valid && !accept.
- An EOF id at the head of the info FIFO sets idle_o=1. Its samples are consumed but produce no beats.
- Full throughput is 1 beat/cycle.
- For LANES=8, x%8 is always 0.

Decomposition:
- jpeg_output_pkg holds the mode constants, block-type constants (Y, CB, CR, EOF), and the four coefficients 5743, 2925, 1410, 7258.
- Sub-module jpeg_output_csc_lane: one lane of the multiply, sum and saturate datapath. It is instantiated LANES times. Sequencing stays in the top module.

Test Plan:
- LANES=1, mono, 16x8 image, Y all 0, two blocks -> 128 beats, rgb=808080, x 0..15, y 0..7, last on beats 63 and 127, then EOF sets idle_o=1.
- LANES=4, 444, Y=0, Cr=100, Cb=0 -> R=128+140=255 saturated, G=128-71=57, B=128. 16 beats per block; lane-0 x steps 0,4.
- 420 with levels 256 -> four consecutive blocks activate without waiting; at sub==0 with level 255, active stays 0.
- Width 10, LANES=4, block x=1 -> beats at x=8 have mask=0011; beats at x=12 have mask 0 and are not emitted.
- Random outport_accept_i backpressure (50%) -> beat sequence identical to the no-stall run, and no data changes while stalled.
- rst_ni low mid-block, then img_start_i -> all outputs 0, idle_o=1; a fresh image decodes starting at idx 0.

Source files
------------

// File: rtl/jpeg_output_pkg.sv
// rtl/jpeg_output_pkg.sv - shared constants and saturation helper for the JPEG pixel emitter
package jpeg_output_pkg;

    localparam logic [1:0] MODE_MONO = 2'd0;
    localparam logic [1:0] MODE_444  = 2'd1;
    localparam logic [1:0] MODE_420  = 2'd2;
    localparam logic [1:0] MODE_422  = 2'd3;

    localparam logic [1:0] BLK_Y   = 2'd0;
    localparam logic [1:0] BLK_CB  = 2'd1;
    localparam logic [1:0] BLK_CR  = 2'd2;
    localparam logic [1:0] BLK_EOF = 2'd3;

    localparam logic [31:0] COEF_CR_R = 32'd5743;
    localparam logic [31:0] COEF_CR_G = 32'd2925;
    localparam logic [31:0] COEF_CB_G = 32'd1410;
    localparam logic [31:0] COEF_CB_B = 32'd7258;

    function automatic logic [7:0] sat_u8(input logic signed [39:0] v);
        if (v < 0) begin
            return 8'd0;
        end else if (v > 255) begin
            return 8'hFF;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/jpeg_output_csc_lane.sv
// rtl/jpeg_output_csc_lane.sv - one lane of the YCbCr->RGB multiply, sum and saturate pipeline
module jpeg_output_csc_lane
    import jpeg_output_pkg::*;
#(
    parameter int COEF_FRAC = 12
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        s1_en_i,
    input  logic        s2_en_i,
    input  logic        mono_i,
    input  logic [31:0] y_i,
    input  logic [31:0] cb_i,
    input  logic [31:0] cr_i,
    output logic [23:0] rgb_o
);

    function automatic logic signed [39:0] mul_shift(input logic [31:0] s, input logic [31:0] c);
        logic signed [63:0] se;
        logic signed [63:0] ce;
        logic signed [63:0] p;
        se = {{32{s[31]}}, s};
        ce = {32'd0, c};
        p  = (se * ce) >>> COEF_FRAC;
        return p[39:0];
    endfunction

    logic signed [31:0] y_q, y_d;
    logic signed [39:0] cra_q, cra_d, crg_q, crg_d, cbg_q, cbg_d, cbb_q, cbb_d;
    logic [23:0]        rgb_q, rgb_d;
    logic signed [39:0] y_ext, yb;

    always_comb begin
        y_d   = y_q;
        cra_d = cra_q;
        crg_d = crg_q;
        cbg_d = cbg_q;
        cbb_d = cbb_q;
        rgb_d = rgb_q;
        y_ext = {{8{y_q[31]}}, y_q};
        yb    = y_ext + 40'sd128;
        if (s1_en_i) begin
            y_d   = y_i;
            cra_d = mul_shift(cr_i, COEF_CR_R);
            crg_d = mul_shift(cr_i, COEF_CR_G);
            cbg_d = mul_shift(cb_i, COEF_CB_G);
            cbb_d = mul_shift(cb_i, COEF_CB_B);
        end
        if (s2_en_i) begin
            if (mono_i) begin
                rgb_d = {3{sat_u8(yb)}};
            end else begin
                rgb_d = {sat_u8(yb + cra_q), sat_u8(yb - cbg_q - crg_q), sat_u8(yb + cbb_q)};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            y_q   <= '0;
            cra_q <= '0;
            crg_q <= '0;
            cbg_q <= '0;
            cbb_q <= '0;
            rgb_q <= '0;
        end else begin
            y_q   <= y_d;
            cra_q <= cra_d;
            crg_q <= crg_d;
            cbg_q <= cbg_d;
            cbb_q <= cbb_d;
            rgb_q <= rgb_d;
        end
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/jpeg_output_cvt.sv
// rtl/jpeg_output_cvt.sv - 8x8 block sequencer and two-stage pixel pipeline for the JPEG decoder output
module jpeg_output_cvt
    import jpeg_output_pkg::*;
#(
    parameter int LANES     = 1,
    parameter int COEF_FRAC = 12,
    parameter int LEVEL_W   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 img_start_i,
    input  logic [15:0]          img_width_i,
    input  logic [15:0]          img_height_i,
    input  logic [1:0]           img_mode_i,
    input  logic [LEVEL_W-1:0]   y_level_i,
    input  logic [LEVEL_W-1:0]   cb_level_i,
    input  logic [LEVEL_W-1:0]   cr_level_i,
    input  logic [LANES*32-1:0]  y_data_i,
    input  logic [LANES*32-1:0]  cb_data_i,
    input  logic [LANES*32-1:0]  cr_data_i,
    output logic                 smp_pop_o,
    input  logic                 id_valid_i,
    input  logic [31:0]          id_data_i,
    output logic                 id_pop_o,
    output logic                 outport_valid_o,
    input  logic                 outport_accept_i,
    output logic [15:0]          outport_pixel_x_o,
    output logic [15:0]          outport_pixel_y_o,
    output logic [LANES*24-1:0]  outport_rgb_o,
    output logic [LANES-1:0]     outport_mask_o,
    output logic                 outport_last_o,
    output logic                 idle_o
);

    localparam logic [5:0] IDX_LAST = 6'(64 - LANES);

    logic [5:0]       idx_q, idx_d;
    logic [1:0]       sub_q, sub_d;
    logic             active_q, active_d;
    logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic             s1_eof_q, s1_eof_d, s1_mono_q, s1_mono_d;
    logic [15:0]      s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [15:0]      out_x_q, out_x_d, out_y_q, out_y_d;
    logic [LANES-1:0] out_mask_q, out_mask_d, mask_d;
    logic             idle_q, idle_d;

    logic pipe_en, adv, idx_wrap, head_eof, act_ok;
    logic y64, all64, all128, all256;
    logic id_unused;

    assign id_unused = ^{id_data_i[29], id_data_i[15:13]};
    assign head_eof  = (id_data_i[31:30] == BLK_EOF);
    assign pipe_en   = !out_valid_q || outport_accept_i;
    assign adv       = active_q && id_valid_i && (!s1_valid_q || pipe_en);
    assign idx_wrap  = (idx_q == IDX_LAST);

    assign y64    = y_level_i >= LEVEL_W'(64);
    assign all64  = y64 && (cb_level_i >= LEVEL_W'(64)) && (cr_level_i >= LEVEL_W'(64));
    assign all128 = (y_level_i >= LEVEL_W'(128)) && (cb_level_i >= LEVEL_W'(128)) &&
                    (cr_level_i >= LEVEL_W'(128));
    assign all256 = (y_level_i >= LEVEL_W'(256)) && (cb_level_i >= LEVEL_W'(256)) &&
                    (cr_level_i >= LEVEL_W'(256));

    // Subsampled modes only check levels on the first block of each chroma group.
    always_comb begin
        act_ok = 1'b0;
        case (img_mode_i)
            MODE_MONO: act_ok = y64;
            MODE_444:  act_ok = all64;
            MODE_420:  act_ok = (sub_q == 2'd0) ? all256 : 1'b1;
            default:   act_ok = !sub_q[0] ? all128 : 1'b1;
        endcase
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            mask_d[k] = ((17'(s1_x_q) + 17'(k)) < 17'(img_width_i)) && (s1_y_q < img_height_i);
        end
    end

    always_comb begin
        idx_d       = idx_q;
        sub_d       = sub_q;
        active_d    = active_q;
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_y_d      = s1_y_q;
        s1_last_d   = s1_last_q;
        s1_eof_d    = s1_eof_q;
        s1_mono_d   = s1_mono_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_mask_d  = out_mask_q;
        out_last_d  = out_last_q;
        idle_d      = idle_q;

        if (!id_valid_i) begin
            active_d = 1'b0;
        end else if (!active_q) begin
            active_d = act_ok;
        end else if (adv && idx_wrap) begin
            active_d = 1'b0;
        end

        if (adv) begin
            idx_d = idx_wrap ? 6'd0 : idx_q + 6'(LANES);
            if (idx_wrap) begin
                case (img_mode_i)
                    MODE_420: sub_d = sub_q + 2'd1;
                    MODE_422: sub_d = {1'b0, ~sub_q[0]};
                    default:  sub_d = 2'd0;
                endcase
            end
            s1_x_d    = {id_data_i[12:0], idx_q[2:0]};
            s1_y_d    = {id_data_i[28:16], idx_q[5:3]};
            s1_last_d = idx_wrap;
            s1_eof_d  = head_eof;
            s1_mono_d = (img_mode_i == MODE_MONO);
        end
        s1_valid_d = adv ? 1'b1 : (pipe_en ? 1'b0 : s1_valid_q);

        if (pipe_en) begin
            out_valid_d = s1_valid_q && !s1_eof_q && (|mask_d);
            out_x_d     = s1_x_q;
            out_y_d     = s1_y_q;
            out_mask_d  = mask_d;
            out_last_d  = s1_last_q;
        end

        if (id_valid_i && head_eof) begin
            idle_d = 1'b1;
        end

        if (img_start_i) begin
            idx_d       = 6'd0;
            sub_d       = 2'd0;
            active_d    = 1'b0;
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            idle_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_q       <= '0;
            sub_q       <= '0;
            active_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_last_q   <= 1'b0;
            s1_eof_q    <= 1'b0;
            s1_mono_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_mask_q  <= '0;
            out_last_q  <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            idx_q       <= idx_d;
            sub_q       <= sub_d;
            active_q    <= active_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_last_q   <= s1_last_d;
            s1_eof_q    <= s1_eof_d;
            s1_mono_q   <= s1_mono_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_mask_q  <= out_mask_d;
            out_last_q  <= out_last_d;
            idle_q      <= idle_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        jpeg_output_csc_lane #(
            .COEF_FRAC(COEF_FRAC)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .s1_en_i (adv),
            .s2_en_i (pipe_en),
            .mono_i  (s1_mono_q),
            .y_i     (y_data_i[32*k +: 32]),
            .cb_i    (cb_data_i[32*k +: 32]),
            .cr_i    (cr_data_i[32*k +: 32]),
            .rgb_o   (outport_rgb_o[24*k +: 24])
        );
    end

    assign smp_pop_o         = adv;
    assign id_pop_o          = adv && idx_wrap;
    assign outport_valid_o   = out_valid_q;
    assign outport_pixel_x_o = out_x_q;
    assign outport_pixel_y_o = out_y_q;
    assign outport_mask_o    = out_mask_q;
    assign outport_last_o    = out_last_q;
    assign idle_o            = idle_q;

endmodule

// File: tb/tb_jpeg_output_cvt.sv
// tb/tb_jpeg_output_cvt.sv - directed table-driven bench for jpeg_output_cvt with four lanes
module tb_jpeg_output_cvt;

    localparam int LANES = 4;

    logic                clk = 1'b0;
    logic                rst_ni, img_start_i;
    logic [15:0]         img_width_i, img_height_i;
    logic [1:0]          img_mode_i;
    logic [31:0]         y_level_i, cb_level_i, cr_level_i;
    logic [LANES*32-1:0] y_data_i, cb_data_i, cr_data_i;
    logic                smp_pop_o, id_valid_i, id_pop_o;
    logic [31:0]         id_data_i;
    logic                outport_valid_o, outport_accept_i, outport_last_o, idle_o;
    logic [15:0]         outport_pixel_x_o, outport_pixel_y_o;
    logic [LANES*24-1:0] outport_rgb_o;
    logic [LANES-1:0]    outport_mask_o;

    always #5 clk = ~clk;

    jpeg_output_cvt #(.LANES(LANES), .COEF_FRAC(12), .LEVEL_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .img_start_i(img_start_i),
        .img_width_i(img_width_i), .img_height_i(img_height_i), .img_mode_i(img_mode_i),
        .y_level_i(y_level_i), .cb_level_i(cb_level_i), .cr_level_i(cr_level_i),
        .y_data_i(y_data_i), .cb_data_i(cb_data_i), .cr_data_i(cr_data_i),
        .smp_pop_o(smp_pop_o), .id_valid_i(id_valid_i), .id_data_i(id_data_i), .id_pop_o(id_pop_o),
        .outport_valid_o(outport_valid_o), .outport_accept_i(outport_accept_i),
        .outport_pixel_x_o(outport_pixel_x_o), .outport_pixel_y_o(outport_pixel_y_o),
        .outport_rgb_o(outport_rgb_o), .outport_mask_o(outport_mask_o),
        .outport_last_o(outport_last_o), .idle_o(idle_o)
    );

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  mask;
        logic        last;
        logic [95:0] rgb;
    } beat_t;

    typedef struct {
        logic [1:0]  mode;
        int          bx;
        int          by;
        logic [31:0] yv;
        logic [31:0] cbv;
        logic [31:0] crv;
        int          w;
        int          h;
        logic [23:0] rgb;
        bit          bp;
    } vec_t;

    int    passed = 0, total = 0;
    beat_t obs[$];
    int    obs_rd = 0, pop_cnt = 0, pop_base = 0, cyc = 0, pop_cyc = -1, val_cyc = -1;
    bit    lat_arm = 0, bp_en = 0, prev_stall = 0, last_valid = 0, last_id_pop = 0;
    beat_t snap;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic sample();
        beat_t cur;
        cur = {outport_pixel_x_o, outport_pixel_y_o, outport_mask_o, outport_last_o, outport_rgb_o};
        if (outport_valid_o && outport_accept_i) obs.push_back(cur);
        if (smp_pop_o) pop_cnt++;
        if (lat_arm && smp_pop_o && pop_cyc < 0) pop_cyc = cyc;
        if (lat_arm && outport_valid_o && val_cyc < 0) val_cyc = cyc;
        if (prev_stall) chk("stall_hold", {outport_valid_o, cur}, {1'b1, snap});
        prev_stall  = outport_valid_o && !outport_accept_i;
        snap        = cur;
        last_valid  = outport_valid_o;
        last_id_pop = id_pop_o;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
        outport_accept_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic run_block(input logic [1:0] mode, input int bx, input int by, input logic [1:0] typ,
                             input logic [31:0] yv, input logic [31:0] cbv, input logic [31:0] crv,
                             input int lvl, input int bound, output bit popped);
        int q;
        img_mode_i = mode;
        id_data_i  = {typ, 14'(by), 16'(bx)};
        y_data_i   = {LANES{yv}};
        cb_data_i  = {LANES{cbv}};
        cr_data_i  = {LANES{crv}};
        y_level_i  = 32'(lvl);
        cb_level_i = 32'(lvl);
        cr_level_i = 32'(lvl);
        id_valid_i = 1'b1;
        popped = 0;
        for (int c = 0; c < bound && !popped; c++) begin
            tick();
            if (last_id_pop) popped = 1;
        end
        id_valid_i = 1'b0;
        q = 0;
        for (int c = 0; c < 200 && q < 4; c++) begin
            tick();
            if (!last_valid) q++;
            else q = 0;
        end
        if (q < 4) chk("drain_timeout", 0, 1);
    endtask

    task automatic check_block(input int bx, input int by, input int w, input int h, input logic [23:0] rgb);
        beat_t e[$];
        beat_t b;
        int    x, y;
        for (int n = 0; n < 16; n++) begin
            x = bx * 8 + (n % 2) * 4;
            y = by * 8 + n / 2;
            for (int k = 0; k < 4; k++) b.mask[k] = (x + k < w) && (y < h);
            b.x    = 16'(x);
            b.y    = 16'(y);
            b.last = (n == 15);
            b.rgb  = {4{rgb}};
            if (b.mask != 4'd0) e.push_back(b);
        end
        chk("beat_count", 32'(obs.size() - obs_rd), 32'(e.size()));
        for (int i = 0; i < e.size(); i++)
            if (obs_rd + i < obs.size()) chk($sformatf("beat%0d", i), obs[obs_rd + i], e[i]);
        chk("pop_count", 32'(pop_cnt - pop_base), 32'd16);
        obs_rd   = obs.size();
        pop_base = pop_cnt;
    endtask

    task automatic pulse_start();
        img_start_i = 1'b1;
        tick();
        img_start_i = 1'b0;
        chk("start_idle", idle_o, 1'b0);
    endtask

    vec_t vecs[11];

    initial begin
        bit popped;
        int start;

        vecs[0]  = '{2'd0, 0, 0, 32'd0, 32'd0, 32'd0, 16, 8, 24'h808080, 1'b0};
        vecs[1]  = '{2'd0, 1, 0, 32'd0, 32'd0, 32'd0, 16, 8, 24'h808080, 1'b0};
        vecs[2]  = '{2'd1, 0, 0, 32'd0, 32'd0, 32'd100, 16, 16, 24'hFF3980, 1'b0};
        vecs[3]  = '{2'd1, 1, 1, 32'hFFFFFF38, 32'd0, 32'd0, 16, 16, 24'h000000, 1'b0};
        vecs[4]  = '{2'd1, 0, 1, 32'd10, 32'hFFFFFFCE, 32'hFFFFFFE2, 16, 16, 24'h5FB231, 1'b0};
        vecs[5]  = '{2'd1, 1, 0, 32'd100, 32'd100, 32'd0, 16, 16, 24'hE4C2FF, 1'b0};
        vecs[6]  = '{2'd0, 0, 0, 32'd50, 32'd100, 32'd100, 16, 16, 24'hB2B2B2, 1'b0};
        vecs[7]  = '{2'd1, 1, 0, 32'd0, 32'd0, 32'd100, 10, 16, 24'hFF3980, 1'b0};
        vecs[8]  = '{2'd1, 0, 1, 32'd0, 32'd0, 32'd0, 16, 12, 24'h808080, 1'b0};
        vecs[9]  = '{2'd1, 1, 1, 32'd10, 32'hFFFFFFCE, 32'hFFFFFFE2, 16, 16, 24'h5FB231, 1'b1};
        vecs[10] = '{2'd0, 0, 0, 32'd0, 32'd0, 32'd0, 16, 16, 24'h808080, 1'b1};

        rst_ni = 1'b0; img_start_i = 1'b0; img_width_i = 16'd16; img_height_i = 16'd8;
        img_mode_i = 2'd0; y_level_i = '0; cb_level_i = '0; cr_level_i = '0;
        y_data_i = '0; cb_data_i = '0; cr_data_i = '0; id_valid_i = 1'b0; id_data_i = '0;
        outport_accept_i = 1'b1;
        repeat (3) tick();
        chk("rst_valid", outport_valid_o, 1'b0);
        chk("rst_rgb", outport_rgb_o, 96'd0);
        chk("rst_misc", {outport_pixel_x_o, outport_pixel_y_o, outport_mask_o, outport_last_o,
                         smp_pop_o, id_pop_o}, 40'd0);
        chk("rst_idle", idle_o, 1'b1);
        rst_ni = 1'b1;
        pulse_start();

        for (int i = 0; i < 11; i++) begin
            img_width_i  = 16'(vecs[i].w);
            img_height_i = 16'(vecs[i].h);
            bp_en        = vecs[i].bp;
            lat_arm      = (i == 0);
            obs_rd       = obs.size();
            pop_base     = pop_cnt;
            start        = obs_rd;
            run_block(vecs[i].mode, vecs[i].bx, vecs[i].by, 2'd0, vecs[i].yv, vecs[i].cbv,
                      vecs[i].crv, 1000, 300, popped);
            chk($sformatf("popped_v%0d", i), popped, 1'b1);
            check_block(vecs[i].bx, vecs[i].by, vecs[i].w, vecs[i].h, vecs[i].rgb);
            if (i == 0) chk("latency", 32'(val_cyc - pop_cyc), 32'd2);
            if (vecs[i].w == 10 && start < obs.size())
                chk("crop_mask", {obs[start].x, obs[start].mask}, {16'd8, 4'b0011});
            bp_en = 1'b0;
            lat_arm = 1'b0;
        end

        img_width_i = 16'd16; img_height_i = 16'd16;
        run_block(2'd1, 0, 0, 2'd3, 32'd0, 32'd0, 32'd0, 1000, 200, popped);
        chk("eof_popped", popped, 1'b1);
        chk("eof_no_beats", 32'(obs.size() - obs_rd), 32'd0);
        chk("eof_pops", 32'(pop_cnt - pop_base), 32'd16);
        chk("eof_idle", idle_o, 1'b1);

        pulse_start();
        run_block(2'd2, 0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 256, 100, popped);
        chk("420_b0", popped, 1'b1);
        for (int b = 1; b < 4; b++) begin
            run_block(2'd2, 0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 0, 100, popped);
            chk($sformatf("420_b%0d", b), popped, 1'b1);
        end
        run_block(2'd2, 0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 255, 30, popped);
        chk("420_hold", popped, 1'b0);
        run_block(2'd2, 0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 256, 100, popped);
        chk("420_resume", popped, 1'b1);

        pulse_start();
        run_block(2'd3, 0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 128, 100, popped);
        chk("422_b0", popped, 1'b1);
        run_block(2'd3, 0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 0, 100, popped);
        chk("422_b1", popped, 1'b1);
        run_block(2'd3, 0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 0, 30, popped);
        chk("422_hold", popped, 1'b0);

        pulse_start();
        img_mode_i = 2'd1; id_data_i = {2'd0, 14'd1, 16'd1};
        y_data_i = {LANES{32'd10}}; cb_data_i = {LANES{32'hFFFFFFCE}}; cr_data_i = {LANES{32'hFFFFFFE2}};
        y_level_i = 32'd1000; cb_level_i = 32'd1000; cr_level_i = 32'd1000;
        id_valid_i = 1'b1;
        pop_base = pop_cnt;
        for (int c = 0; c < 100 && (pop_cnt - pop_base) < 5; c++) tick();
        chk("mid_block_pops", 32'(pop_cnt - pop_base), 32'd5);
        rst_ni = 1'b0; img_start_i = 1'b1; id_valid_i = 1'b0;
        tick();
        tick();
        chk("mid_rst_valid", outport_valid_o, 1'b0);
        chk("mid_rst_rgb", outport_rgb_o, 96'd0);
        chk("mid_rst_misc", {outport_pixel_x_o, outport_pixel_y_o, outport_mask_o, outport_last_o,
                             smp_pop_o, id_pop_o}, 40'd0);
        chk("mid_rst_idle", idle_o, 1'b1);
        rst_ni = 1'b1; img_start_i = 1'b0;
        tick();
        pulse_start();
        obs_rd = obs.size();
        pop_base = pop_cnt;
        run_block(2'd1, 1, 1, 2'd0, 32'd10, 32'hFFFFFFCE, 32'hFFFFFFE2, 1000, 200, popped);
        chk("fresh_popped", popped, 1'b1);
        check_block(1, 1, 16, 16, 24'h5FB231);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
